xadac_vresp: RTL and testbench

XADAC_VRESP -- requirements
Module: xadac_vresp

---
 rtl/xadac_if.sv | 39 +++
 rtl/xadac_vresp.sv | 122 ++++++++++++
 tb/tb_xadac_vresp.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadac_if.sv
// xadac protocol bundle: decode and execute request/response channels with valid/ready pairs.
interface xadac_if;
   logic        dec_req_valid;
   logic        dec_req_ready;
   logic [4:0]  dec_req_id;
   logic [31:0] dec_req_instr;

   logic        dec_rsp_valid;
   logic        dec_rsp_ready;
   logic [4:0]  dec_rsp_id;
   logic        dec_rsp_accept;
   logic        dec_rsp_vd_clobber;
   logic [2:0]  dec_rsp_vs_read;

   logic        exe_req_valid;
   logic        exe_req_ready;
   logic [4:0]  exe_req_id;
   logic [31:0] exe_req_instr;

   logic        exe_rsp_valid;
   logic        exe_rsp_ready;
   logic [4:0]  exe_rsp_id;
   logic        exe_rsp_rd_we;
   logic [31:0] exe_rsp_rd_data;

   modport mst (
      output dec_req_valid, dec_req_id, dec_req_instr, dec_rsp_ready,
      output exe_req_valid, exe_req_id, exe_req_instr, exe_rsp_ready,
      input  dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read,
      input  exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_rd_we, exe_rsp_rd_data
   );

   modport slv (
      input  dec_req_valid, dec_req_id, dec_req_instr, dec_rsp_ready,
      input  exe_req_valid, exe_req_id, exe_req_instr, exe_rsp_ready,
      output dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read,
      output exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_rd_we, exe_rsp_rd_data
   );
endinterface

// File: rtl/xadac_vresp.sv
// xadac vector responder: decode/execute 1-entry response buffers over a lane-wise 8-bit VRF.
// Define XADAC_VRESP_SAT_EN for unsigned saturating vadd/vsub instead of wrap-around.
module xadac_vresp_lane (
   input  logic [2:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   logic [7:0] add_r, sub_r;
`ifdef XADAC_VRESP_SAT_EN
   logic [8:0] sum, dif;
   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      dif   = {1'b0, a} - {1'b0, b};
      add_r = sum[8] ? 8'hFF : sum[7:0];
      sub_r = dif[8] ? 8'h00 : dif[7:0];
   end
`else
   always_comb begin
      add_r = a + b;
      sub_r = a - b;
   end
`endif
   always_comb begin
      y = 8'h00;
      case (op)
         3'd0: y = add_r;
         3'd1: y = sub_r;
         3'd2: y = a & b;
         3'd3: y = a | b;
         3'd4: y = a ^ b;
         3'd5: y = a;
         default: y = 8'h00;
      endcase
   end
endmodule

module xadac_vresp #(
   parameter int NoVecP = 32,
   parameter int VecW   = 64
) (
   input  logic            clk,
   input  logic            rst,
   xadac_if.slv            slv,
   input  logic [4:0]      dbg_addr,
   output logic [VecW-1:0] dbg_vd
);
   localparam int NL = VecW / 8;
   localparam logic [6:0] OpcVec = 7'b0001011;

   function automatic logic dec_ok(input logic [31:0] instr);
      return (instr[6:0] == OpcVec) && (instr[14:12] <= 3'd5);
   endfunction

   logic [NoVecP-1:0][VecW-1:0] vrf;
   logic [VecW-1:0]             opa, opb;
   logic [NL-1:0][7:0]          res;
   logic                        dec_hs, exe_hs, d_ok, e_ok;
   logic                        unused_instr;

   assign unused_instr = ^{slv.dec_req_instr[31:15], slv.dec_req_instr[11:7], slv.exe_req_instr[31:25]};

   // ---------------- decode path ----------------
   assign slv.dec_req_ready = !slv.dec_rsp_valid || slv.dec_rsp_ready;
   assign dec_hs            = slv.dec_req_valid && slv.dec_req_ready;
   assign d_ok              = dec_ok(slv.dec_req_instr);

   always_ff @(posedge clk) begin
      if (rst) begin
         slv.dec_rsp_valid      <= 1'b0;
         slv.dec_rsp_id         <= '0;
         slv.dec_rsp_accept     <= 1'b0;
         slv.dec_rsp_vd_clobber <= 1'b0;
         slv.dec_rsp_vs_read    <= '0;
      end else if (dec_hs) begin
         slv.dec_rsp_valid      <= 1'b1;
         slv.dec_rsp_id         <= slv.dec_req_id;
         slv.dec_rsp_accept     <= d_ok;
         slv.dec_rsp_vd_clobber <= d_ok;
         // vmv (funct3 5) is the only op with a single vector source
         slv.dec_rsp_vs_read    <= d_ok ? {1'b0, slv.dec_req_instr[14:12] != 3'd5, 1'b1} : 3'b000;
      end else if (slv.dec_rsp_ready) begin
         slv.dec_rsp_valid      <= 1'b0;
      end
   end

   // ---------------- execute path ----------------
   assign slv.exe_req_ready   = !slv.exe_rsp_valid || slv.exe_rsp_ready;
   assign exe_hs              = slv.exe_req_valid && slv.exe_req_ready;
   assign e_ok                = dec_ok(slv.exe_req_instr);
   assign slv.exe_rsp_rd_we   = 1'b0;
   assign slv.exe_rsp_rd_data = '0;

   assign opa = vrf[slv.exe_req_instr[19:15]];
   assign opb = vrf[slv.exe_req_instr[24:20]];

   for (genvar g = 0; g < NL; g++) begin : g_lane
      xadac_vresp_lane u_lane (
         .op (slv.exe_req_instr[14:12]),
         .a  (opa[g*8 +: 8]),
         .b  (opb[g*8 +: 8]),
         .y  (res[g])
      );
   end

   // Writing the VRF on the handshake edge lets a back-to-back request see the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         vrf               <= '0;
         slv.exe_rsp_valid <= 1'b0;
         slv.exe_rsp_id    <= '0;
      end else if (exe_hs) begin
         slv.exe_rsp_valid <= 1'b1;
         slv.exe_rsp_id    <= slv.exe_req_id;
         if (e_ok) vrf[slv.exe_req_instr[11:7]] <= res;
      end else if (slv.exe_rsp_ready) begin
         slv.exe_rsp_valid <= 1'b0;
      end
   end

   assign dbg_vd = vrf[dbg_addr];
endmodule

// File: tb/tb_xadac_vresp.sv
// Randomized + directed bench for xadac_vresp against a lane-arithmetic reference model.
module tb_xadac_vresp;
   localparam int VecW = 64;
   localparam int NL   = VecW / 8;
`ifdef XADAC_VRESP_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      dbg_addr;
   logic [VecW-1:0] dbg_vd;

   always #5 clk = ~clk;

   xadac_if bus ();

   xadac_vresp #(.NoVecP(32), .VecW(VecW)) dut (
      .clk      (clk),
      .rst      (rst),
      .slv      (bus),
      .dbg_addr (dbg_addr),
      .dbg_vd   (dbg_vd)
   );

   // reference model state
   logic [VecW-1:0] m_vrf [32];
   bit              m_dv, m_dacc, m_dclb, m_ev;
   logic [4:0]      m_did, m_eid;
   logic [2:0]      m_dvs;
   int              n_chk, n_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int f3, input int rd, input int rs1, input int rs2,
                                      input logic [6:0] opc = 7'b0001011);
      logic [2:0] f;
      logic [4:0] d, s1, s2;
      f = f3[2:0]; d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
      return {7'd0, s2, s1, f, d, opc};
   endfunction

   function automatic bit is_vec(input logic [31:0] i);
      return (i[6:0] == 7'b0001011) && (i[14:12] inside {[3'd0:3'd5]});
   endfunction

   function automatic logic [VecW-1:0] alu(input int f3, input logic [VecW-1:0] a, input logic [VecW-1:0] b);
      logic [VecW-1:0] o;
      int x, y, r;
      o = '0;
      for (int l = 0; l < NL; l++) begin
         x = int'(a[l*8 +: 8]);
         y = int'(b[l*8 +: 8]);
         case (f3)
            0: r = SAT ? ((x + y > 255) ? 255 : x + y) : (x + y) % 256;
            1: r = SAT ? ((x < y) ? 0 : x - y) : (x - y + 256) % 256;
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = x;
            default: r = 0;
         endcase
         o[l*8 +: 8] = r[7:0];
      end
      return o;
   endfunction

   // advance the model across the next rising edge using the inputs now being driven
   task automatic model_edge();
      bit dhs, ehs;
      logic [31:0] i;
      if (rst) begin
         m_dv = 0; m_dacc = 0; m_dclb = 0; m_did = '0; m_dvs = '0;
         m_ev = 0; m_eid = '0;
         for (int r = 0; r < 32; r++) m_vrf[r] = '0;
      end else begin
         dhs = bus.dec_req_valid && (!m_dv || bus.dec_rsp_ready);
         ehs = bus.exe_req_valid && (!m_ev || bus.exe_rsp_ready);
         if (dhs) begin
            i = bus.dec_req_instr;
            m_dv = 1; m_did = bus.dec_req_id;
            m_dacc = is_vec(i); m_dclb = is_vec(i);
            m_dvs = !is_vec(i) ? 3'b000 : (i[14:12] == 3'd5) ? 3'b001 : 3'b011;
         end else if (bus.dec_rsp_ready) m_dv = 0;
         if (ehs) begin
            i = bus.exe_req_instr;
            m_ev = 1; m_eid = bus.exe_req_id;
            if (is_vec(i)) m_vrf[i[11:7]] = alu(int'(i[14:12]), m_vrf[i[19:15]], m_vrf[i[24:20]]);
         end else if (bus.exe_rsp_ready) m_ev = 0;
      end
   endtask

   task automatic check_outputs();
      logic [4:0] a;
      chk("dec_rsp_valid", 64'(bus.dec_rsp_valid), 64'(m_dv));
      chk("dec_rsp_id", 64'(bus.dec_rsp_id), 64'(m_did));
      chk("dec_rsp_accept", 64'(bus.dec_rsp_accept), 64'(m_dacc));
      chk("dec_rsp_vd_clobber", 64'(bus.dec_rsp_vd_clobber), 64'(m_dclb));
      chk("dec_rsp_vs_read", 64'(bus.dec_rsp_vs_read), 64'(m_dvs));
      chk("dec_req_ready", 64'(bus.dec_req_ready), 64'(!m_dv || bus.dec_rsp_ready));
      chk("exe_rsp_valid", 64'(bus.exe_rsp_valid), 64'(m_ev));
      chk("exe_rsp_id", 64'(bus.exe_rsp_id), 64'(m_eid));
      chk("exe_rsp_rd_we", 64'(bus.exe_rsp_rd_we), 64'd0);
      chk("exe_rsp_rd_data", 64'(bus.exe_rsp_rd_data), 64'd0);
      chk("exe_req_ready", 64'(bus.exe_req_ready), 64'(!m_ev || bus.exe_rsp_ready));
      a = 5'($urandom_range(0, 31));
      dbg_addr = a;
      #1;
      chk("vrf_dbg", dbg_vd, m_vrf[a]);
   endtask

   task automatic cycle();
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic rd(input int r, output logic [VecW-1:0] v);
      dbg_addr = r[4:0];
      #1;
      v = dbg_vd;
   endtask

   task automatic poke(input int r, input logic [VecW-1:0] v);
      dut.vrf[r] = v;
      m_vrf[r] = v;
   endtask

   task automatic idle();
      bus.dec_req_valid = 0; bus.dec_req_id = '0; bus.dec_req_instr = '0; bus.dec_rsp_ready = 1;
      bus.exe_req_valid = 0; bus.exe_req_id = '0; bus.exe_req_instr = '0; bus.exe_rsp_ready = 1;
   endtask

   initial begin
      logic [VecW-1:0] v;
      n_chk = 0; n_err = 0;
      rst = 1; dbg_addr = '0;
      idle();
      @(negedge clk);
      cycle(); cycle();
      chk("rst_dec_valid", 64'(bus.dec_rsp_valid), 64'd0);
      chk("rst_exe_valid", 64'(bus.exe_rsp_valid), 64'd0);
      rst = 0;
      cycle();

      // decode examples
      bus.dec_req_valid = 1; bus.dec_req_id = 5'd5; bus.dec_req_instr = mk(0, 3, 1, 2);
      cycle();
      chk("dec_vadd_valid", 64'(bus.dec_rsp_valid), 64'd1);
      chk("dec_vadd_id", 64'(bus.dec_rsp_id), 64'd5);
      chk("dec_vadd_accept", 64'(bus.dec_rsp_accept), 64'd1);
      chk("dec_vadd_clobber", 64'(bus.dec_rsp_vd_clobber), 64'd1);
      chk("dec_vadd_vs_read", 64'(bus.dec_rsp_vs_read), 64'b011);
      bus.dec_req_id = 5'd6; bus.dec_req_instr = mk(0, 3, 1, 2, 7'b0110011);
      cycle();
      chk("dec_bad_id", 64'(bus.dec_rsp_id), 64'd6);
      chk("dec_bad_accept", 64'(bus.dec_rsp_accept), 64'd0);
      chk("dec_bad_vs_read", 64'(bus.dec_rsp_vs_read), 64'd0);
      bus.dec_req_id = 5'd7; bus.dec_req_instr = mk(5, 4, 3, 0);
      cycle();
      chk("dec_vmv_vs_read", 64'(bus.dec_rsp_vs_read), 64'b001);
      bus.dec_req_instr = mk(6, 4, 3, 0);
      cycle();
      chk("dec_f3_6_accept", 64'(bus.dec_rsp_accept), 64'd0);
      bus.dec_req_valid = 0;

      // lane arithmetic at the wrap/saturate boundary
      poke(1, {NL{8'hF0}}); poke(2, {NL{8'h20}});
      bus.exe_req_valid = 1; bus.exe_req_id = 5'd9; bus.exe_req_instr = mk(0, 3, 1, 2);
      cycle();
      chk("exe_vadd_valid", 64'(bus.exe_rsp_valid), 64'd1);
      chk("exe_vadd_id", 64'(bus.exe_rsp_id), 64'd9);
      bus.exe_req_id = 5'd10; bus.exe_req_instr = mk(1, 6, 2, 1);
      cycle();
      bus.exe_req_valid = 0;
      rd(3, v); chk("vadd_v3", v, SAT ? {NL{8'hFF}} : {NL{8'h10}});
      rd(6, v); chk("vsub_v6", v, SAT ? {NL{8'h00}} : {NL{8'h30}});
      cycle();

      // back-to-back: vmv v4,v3 then vxor v5,v4,v4
      poke(4, 64'h1111_2222_3333_4444); poke(5, 64'h0123_4567_89AB_CDEF);
      bus.exe_req_valid = 1; bus.exe_req_id = 5'd1; bus.exe_req_instr = mk(5, 4, 3, 0);
      cycle();
      chk("b2b_rsp1", 64'(bus.exe_rsp_id), 64'd1);
      bus.exe_req_id = 5'd2; bus.exe_req_instr = mk(4, 5, 4, 4);
      cycle();
      chk("b2b_rsp2_valid", 64'(bus.exe_rsp_valid), 64'd1);
      chk("b2b_rsp2", 64'(bus.exe_rsp_id), 64'd2);
      bus.exe_req_valid = 0;
      rd(4, v); chk("b2b_v4", v, SAT ? {NL{8'hFF}} : {NL{8'h10}});
      rd(5, v); chk("b2b_v5", v, 64'd0);
      cycle();

      // backpressure: response held, second request stalled
      poke(8, '0);
      bus.exe_rsp_ready = 0;
      bus.exe_req_valid = 1; bus.exe_req_id = 5'd10; bus.exe_req_instr = mk(0, 7, 1, 1);
      cycle();
      bus.exe_req_id = 5'd11; bus.exe_req_instr = mk(3, 8, 1, 2);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("bp_req_ready", 64'(bus.exe_req_ready), 64'd0);
         chk("bp_rsp_id", 64'(bus.exe_rsp_id), 64'd10);
         rd(8, v); chk("bp_v8", v, 64'd0);
      end
      bus.exe_rsp_ready = 1;
      cycle();
      chk("bp_release_id", 64'(bus.exe_rsp_id), 64'd11);
      bus.exe_req_valid = 0;
      cycle();
      rd(8, v); chk("bp_v8_after", v, {NL{8'hF0}});

      // randomized traffic on both paths
      for (int n = 0; n < 1500; n++) begin
         bus.dec_req_valid = ($urandom_range(0, 3) != 0);
         bus.dec_req_id    = 5'($urandom);
         bus.dec_req_instr = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'b0001011);
         bus.dec_rsp_ready = ($urandom_range(0, 3) != 0);
         bus.exe_req_valid = ($urandom_range(0, 3) != 0);
         bus.exe_req_id    = 5'($urandom);
         bus.exe_req_instr = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'b0001011);
         bus.exe_rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) poke($urandom_range(0, 7), {$urandom, $urandom});
         cycle();
      end

      // reset with both responses pending
      idle();
      cycle();
      bus.dec_rsp_ready = 0; bus.exe_rsp_ready = 0;
      bus.dec_req_valid = 1; bus.dec_req_instr = mk(0, 1, 2, 3);
      bus.exe_req_valid = 1; bus.exe_req_instr = mk(4, 9, 1, 2);
      cycle();
      chk("pre_rst_dec_valid", 64'(bus.dec_rsp_valid), 64'd1);
      chk("pre_rst_exe_valid", 64'(bus.exe_rsp_valid), 64'd1);
      rst = 1;
      cycle();
      chk("rst_dec_valid2", 64'(bus.dec_rsp_valid), 64'd0);
      chk("rst_exe_valid2", 64'(bus.exe_rsp_valid), 64'd0);
      chk("rst_dec_ready", 64'(bus.dec_req_ready), 64'd1);
      chk("rst_exe_ready", 64'(bus.exe_req_ready), 64'd1);
      for (int r = 0; r < 32; r++) begin
         rd(r, v);
         chk("rst_vrf_zero", v, 64'd0);
      end
      @(negedge clk);
      rst = 0;
      bus.dec_req_valid = 0; bus.exe_req_valid = 0;
      cycle();
      chk("post_rst_dec_ready", 64'(bus.dec_req_ready), 64'd1);
      chk("post_rst_exe_ready", 64'(bus.exe_req_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
